// File: rtl/midi_avalon_bridge.sv
// midi_avalon_bridge: MIDI byte parser issuing note/stop-all Avalon-MM writes (byte in: i_byte/i_byte_valid/o_byte_ready; avm_m0_* master out; o_cmd_count completed writes)
module midi_avalon_bridge #(
  parameter logic [3:0] MIDI_CHANNEL = 4'd0,
  parameter bit         OMNI         = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic        avm_m0_write,
  output logic [31:0] avm_m0_writedata,
  input  logic        avm_m0_waitrequest,
  output logic [15:0] o_cmd_count
);
  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;
  state_t      state, state_nx;
  logic [7:0]  rs;
  logic [6:0]  d1;
  logic [6:0]  vel;
  logic        xfer, is_chs, is_sys, is_data, short_msg, ch_ok, note_ok, done, gen;
  logic [15:0] word;
  assign o_byte_ready = !avm_m0_write;
  assign xfer         = i_byte_valid && o_byte_ready;
  assign is_data      = !i_byte[7];
  assign is_chs       = i_byte[7] && i_byte[7:4] != 4'hF;
  assign is_sys       = i_byte[7:4] == 4'hF && !i_byte[3];
  assign short_msg    = rs[7:5] == 3'b110;
  assign ch_ok        = OMNI || rs[3:0] == MIDI_CHANNEL;
  assign note_ok      = d1 != 7'h7F;
  assign vel          = i_byte[6:0];
  assign done         = xfer && is_data && state == WAIT_D2 && ch_ok;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (xfer)
      state_nx = is_chs ? WAIT_D1 :
                 is_sys ? IDLE :
                 !is_data ? state :
                 state == WAIT_D1 ? (short_msg ? WAIT_D1 : WAIT_D2) :
                 state == WAIT_D2 ? WAIT_D1 : IDLE;
  end
  always_comb begin
    gen  = 1'b0;
    word = 16'h0000;
    if (done) begin
      if (rs[7:4] == 4'h9 && note_ok) begin
        gen  = 1'b1;
        word = {|vel, d1, 1'b0, vel};
      end else if (rs[7:4] == 4'h8 && note_ok) begin
        gen  = 1'b1;
        word = {1'b0, d1, 8'h00};
      end else if (rs[7:4] == 4'hB && (d1 == 7'd120 || d1 == 7'd123)) begin
        gen  = 1'b1;
        word = 16'h7F00;
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rs               <= 8'h00;
      d1               <= 7'h00;
      avm_m0_write     <= 1'b0;
      avm_m0_writedata <= 32'h0;
      o_cmd_count      <= 16'h0;
    end else begin
      if (xfer && is_chs) rs <= i_byte;
      else if (xfer && is_sys) rs <= 8'h00;
      if (xfer && is_data && state == WAIT_D1 && !short_msg) d1 <= i_byte[6:0];
      if (gen) begin
        avm_m0_write     <= 1'b1;
        avm_m0_writedata <= {16'h0000, word};
      end else if (avm_m0_write && !avm_m0_waitrequest) begin
        avm_m0_write <= 1'b0;
        o_cmd_count  <= o_cmd_count + 16'd1;
      end
    end
endmodule

// File: tb/tb_midi_avalon_bridge.sv
// tb_midi_avalon_bridge: table-driven byte vectors plus stall and reset sequences
module tb_midi_avalon_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic        avm_m0_write;
  logic [31:0] avm_m0_writedata;
  logic        avm_m0_waitrequest;
  logic [15:0] o_cmd_count;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [7:0]  b;
    logic        wr;
    logic [15:0] data;
    logic [15:0] cnt;
  } vec_t;
  vec_t v[$];
  midi_avalon_bridge #(.MIDI_CHANNEL(4'd0), .OMNI(1'b0)) dut (
    .clk(clk),
    .reset(reset),
    .i_byte(i_byte),
    .i_byte_valid(i_byte_valid),
    .o_byte_ready(o_byte_ready),
    .avm_m0_write(avm_m0_write),
    .avm_m0_writedata(avm_m0_writedata),
    .avm_m0_waitrequest(avm_m0_waitrequest),
    .o_cmd_count(o_cmd_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic [7:0] b, input logic wr, input logic [15:0] data, input logic [15:0] cnt);
    v.push_back('{b, wr, data, cnt});
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!o_byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", {31'h0, o_byte_ready}, 32'h1);
    i_byte = b;
    i_byte_valid = 1'b1;
    @(posedge clk);
    #1;
    i_byte_valid = 1'b0;
  endtask
  initial begin
    reset = 1'b0;
    i_byte = 8'h00;
    i_byte_valid = 1'b0;
    avm_m0_waitrequest = 1'b0;
    #12;
    chk("rst_write", {31'h0, avm_m0_write}, 32'h0);
    chk("rst_data", avm_m0_writedata, 32'h0);
    chk("rst_count", {16'h0, o_cmd_count}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_ready", {31'h0, o_byte_ready}, 32'h1);
    add(8'h90, 0, 16'h0, 0); add(8'h5B, 0, 16'h0, 0); add(8'h40, 1, 16'hDB40, 1);
    add(8'h90, 0, 16'h0, 1); add(8'h3C, 0, 16'h0, 1); add(8'h10, 1, 16'hBC10, 2);
    add(8'h3C, 0, 16'h0, 2); add(8'h00, 1, 16'h3C00, 3);
    add(8'h90, 0, 16'h0, 3); add(8'h5B, 0, 16'h0, 3); add(8'hF8, 0, 16'h0, 3); add(8'h40, 1, 16'hDB40, 4);
    add(8'hB0, 0, 16'h0, 4); add(8'h7B, 0, 16'h0, 4); add(8'h00, 1, 16'h7F00, 5);
    add(8'h91, 0, 16'h0, 5); add(8'h3C, 0, 16'h0, 5); add(8'h40, 0, 16'h0, 5);
    add(8'h80, 0, 16'h0, 5); add(8'h3C, 0, 16'h0, 5); add(8'h55, 1, 16'h3C00, 6);
    add(8'h90, 0, 16'h0, 6); add(8'h7F, 0, 16'h0, 6); add(8'h40, 0, 16'h0, 6);
    add(8'hC0, 0, 16'h0, 6); add(8'h05, 0, 16'h0, 6); add(8'h06, 0, 16'h0, 6);
    add(8'hF0, 0, 16'h0, 6); add(8'h3C, 0, 16'h0, 6); add(8'h40, 0, 16'h0, 6);
    add(8'hE0, 0, 16'h0, 6); add(8'h10, 0, 16'h0, 6); add(8'h20, 0, 16'h0, 6);
    add(8'hB0, 0, 16'h0, 6); add(8'h78, 0, 16'h0, 6); add(8'h00, 1, 16'h7F00, 7);
    add(8'hB0, 0, 16'h0, 7); add(8'h07, 0, 16'h0, 7); add(8'h64, 0, 16'h0, 7);
    add(8'h90, 0, 16'h0, 7); add(8'h45, 0, 16'h0, 7); add(8'h7F, 1, 16'hC57F, 8);
    add(8'h90, 0, 16'h0, 8); add(8'h3C, 0, 16'h0, 8); add(8'h80, 0, 16'h0, 8);
    add(8'h3C, 0, 16'h0, 8); add(8'h10, 1, 16'h3C00, 9);
    foreach (v[i]) begin
      send(v[i].b);
      chk($sformatf("v%0d_write", i), {31'h0, avm_m0_write}, {31'h0, v[i].wr});
      if (v[i].wr) begin
        chk($sformatf("v%0d_data", i), avm_m0_writedata, {16'h0, v[i].data});
        chk($sformatf("v%0d_ready", i), {31'h0, o_byte_ready}, 32'h0);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_write_done", i), {31'h0, avm_m0_write}, 32'h0);
      chk($sformatf("v%0d_count", i), {16'h0, o_cmd_count}, {16'h0, v[i].cnt});
    end
    avm_m0_waitrequest = 1'b1;
    send(8'h90); send(8'h5B); send(8'h40);
    for (int k = 0; k < 5; k++) begin
      chk("stall_write", {31'h0, avm_m0_write}, 32'h1);
      chk("stall_data", avm_m0_writedata, 32'h0000_DB40);
      chk("stall_ready", {31'h0, o_byte_ready}, 32'h0);
      chk("stall_count", {16'h0, o_cmd_count}, 32'd9);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    avm_m0_waitrequest = 1'b0;
    @(posedge clk);
    #1;
    chk("stall_write_done", {31'h0, avm_m0_write}, 32'h0);
    chk("stall_count_done", {16'h0, o_cmd_count}, 32'd10);
    send(8'h90);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_count", {16'h0, o_cmd_count}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    send(8'h5B); send(8'h40);
    chk("after_rst_write", {31'h0, avm_m0_write}, 32'h0);
    @(posedge clk);
    #1;
    chk("after_rst_count", {16'h0, o_cmd_count}, 32'h0);
    avm_m0_waitrequest = 1'b1;
    send(8'h90); send(8'h5B); send(8'h40);
    chk("pend_write", {31'h0, avm_m0_write}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("pend_rst_write", {31'h0, avm_m0_write}, 32'h0);
    chk("pend_rst_data", avm_m0_writedata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    avm_m0_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pend_rst_count", {16'h0, o_cmd_count}, 32'h0);
    chk("pend_rst_ready", {31'h0, o_byte_ready}, 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/midi_avalon_bridge.md
MIDI_AVALON_BRIDGE -- requirements
Module: midi_avalon_bridge

Interface
REQ-001 SHALL have parameter MIDI_CHANNEL, default 0, meaning the 4-bit MIDI channel accepted when OMNI=0.
REQ-002 SHALL have parameter OMNI, default 0, meaning when 1, channel messages on all channels are accepted.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_byte, input, 8, received MIDI byte from the UART.
REQ-006 SHALL have port i_byte_valid, input, 1, i_byte valid this cycle.
REQ-007 SHALL have port o_byte_ready, output, 1, the bridge accepts a byte this cycle; a transfer occurs when valid and ready are both high.
REQ-008 SHALL have port avm_m0_write, output, 1, Avalon-MM write request to synthesizer_top_p avs_s0_write.
REQ-009 SHALL have port avm_m0_writedata, output, 32, command word to avs_s0_writedata.
REQ-010 SHALL have port avm_m0_waitrequest, input, 1, slave stall; tie 0 if the slave never stalls.
REQ-011 SHALL have port o_cmd_count, output, 16, count of completed writes, wrapping.

Function
REQ-012 Command word SHALL be {16'h0000, gate, note[6:0], 1'b0, vel[6:0]}: gate=1 for note-on, gate=0 for note-off.
REQ-013 Parser states SHALL be IDLE (no running status), WAIT_D1, WAIT_D2; running status is held in a 8-bit register rs.
REQ-014 Status byte 0x80-0xEF SHALL load rs and move to WAIT_D1, discarding any partial message.
REQ-015 Status byte 0xF0-0xF7 SHALL clear rs and move to IDLE; data bytes SHALL then be ignored until the next channel status.
REQ-016 Real-time bytes 0xF8-0xFF SHALL be accepted and ignored, with no change to state, rs or partial data.
REQ-017 Data byte (bit7=0) in IDLE SHALL be ignored.
REQ-018 For rs types 0xC/0xD, the data byte in WAIT_D1 SHALL complete the message, which is dropped, and return to WAIT_D1 (running status).
REQ-019 For rs types 0x8/0x9/0xA/0xB/0xE, WAIT_D1 SHALL latch d1 and go to WAIT_D2; the data byte in WAIT_D2 SHALL complete the message and return to WAIT_D1.
REQ-020 Channel mismatch (OMNI=0, rs[3:0]!=MIDI_CHANNEL) SHALL parse normally but generate no write.
REQ-021 On completion, 0x9n with vel>0 SHALL generate gate=1, note=d1, vel=d2.
REQ-022 On completion, 0x8n (any vel) or 0x9n with vel=0 SHALL generate gate=0, note=d1, vel=0.
REQ-023 On completion, 0xBn with d1=120 or d1=123 SHALL generate the stop-all word 32'h0000_7F00.
REQ-024 Note messages with d1=127 (reserved stop-all code) SHALL be dropped.
REQ-025 All other completed messages (0xA, 0xE, other 0xB) SHALL be dropped.
REQ-026 A generated word SHALL appear on avm_m0_writedata with avm_m0_write=1 on the cycle after the completing byte transfer.
REQ-027 avm_m0_write and avm_m0_writedata SHALL hold stable while avm_m0_waitrequest=1; the write completes on the first cycle with write=1 and waitrequest=0, and avm_m0_write deasserts on the next cycle.
REQ-028 o_byte_ready SHALL be 0 while a write is pending (avm_m0_write=1), and 1 otherwise.
REQ-029 o_cmd_count SHALL increment by 1 per completed write, wrapping 16'hFFFF to 0.

Reset
REQ-030 reset=0 SHALL immediately force: state=IDLE, rs=0, d1=0, avm_m0_write=0, avm_m0_writedata=0, o_cmd_count=0, o_byte_ready=1 after release.
REQ-031 Reset during a pending write SHALL abandon the write without completing it and without incrementing the counter.
REQ-032 Outputs SHALL be registered, with no combinational path from i_byte to avm_m0_*.

Verification
REQ-033 Bytes 0x90,0x5B,0x40 with waitrequest=0 -> one write 32'h0000_DB40 one cycle after the last byte, and count=1.
REQ-034 Bytes 0x90,0x3C,0x10,0x3C,0x00 (running status) -> writes 32'h0000_BC10 then 32'h0000_3C00, and count=2.
REQ-035 Bytes 0x90,0x5B,0xF8,0x40 -> single write 32'h0000_DB40, unaffected by the real-time byte.
REQ-036 Bytes 0xB0,0x7B,0x00 -> write 32'h0000_7F00; bytes 0x91,0x3C,0x40 with MIDI_CHANNEL=0, OMNI=0 -> no write.
REQ-037 waitrequest held 1 for 5 cycles during a write -> write and data stable, o_byte_ready=0 throughout, exactly one count increment.
REQ-038 reset asserted between 0x90 and 0x5B, then 0x5B,0x40 sent -> no write (IDLE ignores data), and count=0.
